// File: rtl/mem_align_unit.sv
// Memory-stage load/store sequencer: splits misaligned accesses into aligned
// word reads (loads) or byte writes (stores) and returns one registered response.
module mem_align_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_dataW,
  output logic [2:0]  dm_funct3,
  output logic        dm_MemRW,
  input  logic [31:0] dm_dataR,
  output logic [15:0] split_cnt
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned F3W  = 3;
  localparam int unsigned CNTW = 16;

  localparam logic [F3W-1:0] F3_BYTE = 3'b000;
  localparam logic [F3W-1:0] F3_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCESS  = 3'd1,
    S_LD_LO   = 3'd2,
    S_LD_HI   = 3'd3,
    S_ST_BYTE = 3'd4,
    S_RESP    = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [F3W-1:0]    f3_q, f3_d;
  logic              cross_q, cross_d;
  logic [1:0]        idx_q, idx_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNTW-1:0]   split_q, split_d;
  logic              ready_q, ready_d;
  logic [XLEN-1:0]   dm_addr_q, dm_addr_d;
  logic [XLEN-1:0]   dm_dataW_q, dm_dataW_d;
  logic [F3W-1:0]    dm_f3_q, dm_f3_d;
  logic              dm_we_q, dm_we_d;

  logic              accept_c;
  logic              in_legal_c;
  logic              in_mis_c;
  logic              in_cross_c;
  logic [1:0]        last_idx_c;

  function automatic logic legal_f3(input logic we, input logic [F3W-1:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = !we;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] o);
    logic mis;
    case (sz)
      2'b10:   mis = (o != 2'b00);
      2'b01:   mis = o[0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [F3W-1:0] f3,
                                             input logic [XLEN-1:0] w);
    logic [XLEN-1:0] r;
    case (f3)
      3'b000:  r = {{24{w[7]}}, w[7:0]};
      3'b001:  r = {{16{w[15]}}, w[15:0]};
      3'b100:  r = {24'd0, w[7:0]};
      3'b101:  r = {16'd0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Extract the requested bytes from the {B,A} word pair starting at offset o.
  function automatic logic [XLEN-1:0] pick(input logic [F3W-1:0] f3,
                                           input logic [1:0] o,
                                           input logic [XLEN-1:0] hi,
                                           input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] both;
    both = {hi, lo} >> {o, 3'b000};
    return extend(f3, both[XLEN-1:0]);
  endfunction

  assign accept_c   = req_valid && ready_q;
  assign in_legal_c = legal_f3(req_we, req_funct3);
  assign in_mis_c   = misaligned(req_funct3[1:0], req_addr[1:0]);
  assign in_cross_c = req_funct3[1] || (req_addr[1:0] == 2'b11);

  always_comb begin
    case (f3_q[1:0])
      2'b10:   last_idx_c = 2'd3;
      2'b01:   last_idx_c = 2'd1;
      default: last_idx_c = 2'd0;
    endcase
  end

  // State register and latched request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      cross_q <= 1'b0;
      idx_q   <= 2'd0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      cross_q <= cross_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      split_q     <= '0;
      ready_q     <= 1'b1;
      dm_addr_q   <= '0;
      dm_dataW_q  <= '0;
      dm_f3_q     <= '0;
      dm_we_q     <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      split_q     <= split_d;
      ready_q     <= ready_d;
      dm_addr_q   <= dm_addr_d;
      dm_dataW_q  <= dm_dataW_d;
      dm_f3_q     <= dm_f3_d;
      dm_we_q     <= dm_we_d;
    end
  end

  // Next-state and request latching.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    cross_d = cross_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    case (state_q)
      S_ACCESS: state_d = S_RESP;
      S_LD_LO: begin
        lo_d    = dm_dataR;
        state_d = cross_q ? S_LD_HI : S_RESP;
      end
      S_LD_HI: state_d = S_RESP;
      S_ST_BYTE: begin
        if (idx_q == last_idx_c) begin
          state_d = S_RESP;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (accept_c) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          f3_d    = req_funct3;
          cross_d = in_cross_c;
          idx_d   = 2'd0;
          if (!in_legal_c) begin
            state_d = S_RESP;
          end else if (in_mis_c) begin
            state_d = req_we ? S_ST_BYTE : S_LD_LO;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next values, derived from the upcoming state and fields.
  always_comb begin
    rsp_valid_d = (state_d == S_RESP);
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    split_d     = split_q;
    ready_d     = (state_d == S_IDLE) || (state_d == S_RESP);
    dm_addr_d   = '0;
    dm_dataW_d  = '0;
    dm_f3_d     = '0;
    dm_we_d     = 1'b0;

    case (state_q)
      S_ACCESS: rsp_rdata_d = we_q ? '0 : dm_dataR;
      S_LD_LO: begin
        if (!cross_q) begin
          rsp_rdata_d = pick(f3_q, addr_q[1:0], '0, dm_dataR);
        end
      end
      S_LD_HI: rsp_rdata_d = pick(f3_q, addr_q[1:0], dm_dataR, lo_q);
      S_IDLE, S_RESP: begin
        if (accept_c) begin
          rsp_err_d = !in_legal_c;
          if (in_legal_c && in_mis_c) begin
            split_d = split_q + CNTW'(1);
          end
        end
      end
      default: ;
    endcase

    case (state_d)
      S_ACCESS: begin
        dm_addr_d  = addr_d;
        dm_f3_d    = f3_d;
        dm_we_d    = we_d;
        dm_dataW_d = we_d ? wdata_d : '0;
      end
      S_LD_LO: begin
        dm_addr_d = {addr_d[XLEN-1:2], 2'b00};
        dm_f3_d   = F3_WORD;
      end
      S_LD_HI: begin
        dm_addr_d = {addr_d[XLEN-1:2] + 30'd1, 2'b00};
        dm_f3_d   = F3_WORD;
      end
      S_ST_BYTE: begin
        dm_addr_d  = addr_d + XLEN'(idx_d);
        dm_f3_d    = F3_BYTE;
        dm_we_d    = 1'b1;
        dm_dataW_d = XLEN'(8'(wdata_d >> {idx_d, 3'b000}));
      end
      default: ;
    endcase
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign split_cnt = split_q;
  assign dm_addr   = dm_addr_q;
  assign dm_dataW  = dm_dataW_q;
  assign dm_funct3 = dm_f3_q;
  assign dm_MemRW  = dm_we_q;

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed bench for mem_align_unit with a byte-array model of data_mem.
module tb_mem_align_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_dataW;
  logic [2:0]  dm_funct3;
  logic        dm_MemRW;
  logic [31:0] dm_dataR;
  logic [15:0] split_cnt;

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem [256];
  logic [7:0]  a0, a1, a2, a3;
  logic [31:0] tr_addr [12];
  logic [31:0] tr_dw [12];
  logic [2:0]  tr_f3 [12];
  logic        tr_we [12];
  int          act;
  int          lat;

  always #5 clk = ~clk;

  mem_align_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dm_addr(dm_addr), .dm_dataW(dm_dataW), .dm_funct3(dm_funct3),
    .dm_MemRW(dm_MemRW), .dm_dataR(dm_dataR), .split_cnt(split_cnt)
  );

  // data_mem model: combinational read, synchronous write, little-endian.
  always_comb begin
    a0 = dm_addr[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    case (dm_funct3)
      3'b000:  dm_dataR = {{24{mem[a0][7]}}, mem[a0]};
      3'b001:  dm_dataR = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      3'b100:  dm_dataR = {24'd0, mem[a0]};
      3'b101:  dm_dataR = {16'd0, mem[a1], mem[a0]};
      default: dm_dataR = {mem[a3], mem[a2], mem[a1], mem[a0]};
    endcase
  end

  always @(posedge clk) begin
    if (dm_MemRW) begin
      mem[a0] <= dm_dataW[7:0];
      if (dm_funct3[1:0] != 2'b00) mem[a1] <= dm_dataW[15:8];
      if (dm_funct3[1]) begin
        mem[a2] <= dm_dataW[23:16];
        mem[a3] <= dm_dataW[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Samples each cycle after accept until the response, bounded.
  task automatic collect();
    lat = 0;
    act = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c;
        break;
      end
      tr_addr[c-1] = dm_addr;
      tr_dw[c-1]   = dm_dataW;
      tr_f3[c-1]   = dm_funct3;
      tr_we[c-1]   = dm_MemRW;
      if (dm_MemRW || dm_addr != 32'd0) act++;
    end
  endtask

  task automatic run(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [2:0] f3,
                     input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
    drive(we, addr, wdata, f3);
    collect();
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, "_dm_in_resp"}, dm_addr | 32'(dm_MemRW), 32'd0);
  endtask

  initial begin
    logic [7:0] sb_exp [4];
    sb_exp[0] = 8'hD4; sb_exp[1] = 8'hC3; sb_exp[2] = 8'hB2; sb_exp[3] = 8'hA1;

    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_split", 32'(split_cnt), 32'd0);
    check("rst_dm", dm_addr | dm_dataW | 32'(dm_funct3) | 32'(dm_MemRW), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);

    run("pre10", 1'b1, 32'h10, 32'h44332211, 3'b010, 2, 32'd0, 1'b0);
    check("pre10_we", 32'(tr_we[0]), 32'd1);
    check("pre10_dw", tr_dw[0], 32'h44332211);
    run("pre14", 1'b1, 32'h14, 32'h88776655, 3'b010, 2, 32'd0, 1'b0);

    run("lw10", 1'b0, 32'h10, 32'd0, 3'b010, 2, 32'h44332211, 1'b0);
    check("lw10_addr", tr_addr[0], 32'h10);
    check("lw10_f3", 32'(tr_f3[0]), 32'd2);
    check("lw10_we", 32'(tr_we[0]), 32'd0);
    check("lw10_split", 32'(split_cnt), 32'd0);

    run("lw11", 1'b0, 32'h11, 32'd0, 3'b010, 3, 32'h55443322, 1'b0);
    check("lw11_addr0", tr_addr[0], 32'h10);
    check("lw11_addr1", tr_addr[1], 32'h14);
    check("lw11_f3", 32'({tr_f3[0], tr_f3[1]}), 32'h12);
    check("lw11_split", 32'(split_cnt), 32'd1);

    run("sb14", 1'b1, 32'h14, 32'h000000F5, 3'b000, 2, 32'd0, 1'b0);
    run("lh13", 1'b0, 32'h13, 32'd0, 3'b001, 3, 32'hFFFFF544, 1'b0);
    check("lh13_split", 32'(split_cnt), 32'd2);
    run("lhu13", 1'b0, 32'h13, 32'd0, 3'b101, 3, 32'h0000F544, 1'b0);
    check("lhu13_split", 32'(split_cnt), 32'd3);
    run("lh11", 1'b0, 32'h11, 32'd0, 3'b001, 2, 32'h00003322, 1'b0);
    check("lh11_addr", tr_addr[0], 32'h10);
    check("lh11_split", 32'(split_cnt), 32'd4);

    run("pre20", 1'b1, 32'h20, 32'h44332211, 3'b010, 2, 32'd0, 1'b0);
    run("pre24", 1'b1, 32'h24, 32'h88776655, 3'b010, 2, 32'd0, 1'b0);
    run("sw21", 1'b1, 32'h21, 32'hA1B2C3D4, 3'b010, 5, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sw21_addr%0d", i), tr_addr[i], 32'h21 + 32'(i));
      check($sformatf("sw21_byte%0d", i), 32'(tr_dw[i][7:0]), 32'(sb_exp[i]));
      check($sformatf("sw21_ctl%0d", i), 32'({tr_we[i], tr_f3[i]}), 32'h8);
    end
    check("sw21_split", 32'(split_cnt), 32'd5);
    run("lw20", 1'b0, 32'h20, 32'd0, 3'b010, 2, 32'hB2C3D411, 1'b0);
    run("lw24", 1'b0, 32'h24, 32'd0, 3'b010, 2, 32'h887766A1, 1'b0);

    run("ill_ld", 1'b0, 32'h10, 32'd0, 3'b011, 1, 32'd0, 1'b1);
    check("ill_ld_act", 32'(act), 32'd0);
    run("ill_st", 1'b1, 32'h10, 32'h12345678, 3'b100, 1, 32'd0, 1'b1);
    check("ill_st_act", 32'(act), 32'd0);
    check("ill_split", 32'(split_cnt), 32'd5);

    // Illegal request followed by an aligned lw held valid through RESP.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b011;
    @(posedge clk);
    #1 req_funct3 = 3'b010;
    @(negedge clk);
    check("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
    check("b2b_rsp_err", 32'(rsp_err), 32'd1);
    check("b2b_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("b2b_acc_valid", 32'(rsp_valid), 32'd0);
    check("b2b_acc_addr", dm_addr, 32'h10);
    @(negedge clk);
    check("b2b_lw_valid", 32'(rsp_valid), 32'd1);
    check("b2b_lw_rdata", rsp_rdata, 32'h44332211);
    check("b2b_lw_err", 32'(rsp_err), 32'd0);

    run("pre30", 1'b1, 32'h30, 32'hAABBCCDD, 3'b010, 2, 32'd0, 1'b0);
    run("pre34", 1'b1, 32'h34, 32'h55667788, 3'b010, 2, 32'd0, 1'b0);
    drive(1'b1, 32'h31, 32'h11223344, 3'b010);
    @(negedge clk);
    check("rm_wr0", dm_addr | {31'd0, ~dm_MemRW}, 32'h31);
    @(negedge clk);
    check("rm_wr1", dm_addr | {31'd0, ~dm_MemRW}, 32'h32);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rm_memrw", 32'(dm_MemRW), 32'd0);
    check("rm_split_rst", 32'(split_cnt), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rm_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rm_ready", 32'(req_ready), 32'd1);
    check("rm_split", 32'(split_cnt), 32'd0);
    check("rm_rsp_valid", 32'(rsp_valid), 32'd0);
    run("lw30", 1'b0, 32'h30, 32'd0, 3'b010, 2, 32'hAA3344DD, 1'b0);
    run("lw34", 1'b0, 32'h34, 32'd0, 3'b010, 2, 32'h55667788, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_align_unit.md
# mem_align_unit

Memory-stage load/store sequencer between the EX/MEM pipeline register and `data_mem`. It accepts one load/store request at a time over a valid/ready handshake. Each request becomes one or more accesses on `data_mem`'s combinational-read / synchronous-write port. Misaligned requests are split in hardware: loads use two aligned word reads, stores use per-byte writes. The block returns a single registered response to the writeback stage.

## Interface
- No parameters; address/data width fixed at 32.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; handshake completes on an edge with `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `req_funct3`  in  3  RISC-V width/sign code.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  load result, sign/zero extended; 0 for stores and errors.
- `rsp_err`  out  1  illegal funct3; valid with `rsp_valid`.
- `dm_addr`  out  32  to `data_mem` addr.
- `dm_dataW`  out  32  to `data_mem` dataW.
- `dm_funct3`  out  3  to `data_mem` funct3.
- `dm_MemRW`  out  1  to `data_mem` MemRW (1 = write).
- `dm_dataR`  in  32  from `data_mem` dataR (combinational, same cycle).
- `split_cnt`  out  16  count of accepted split requests, wraps mod 2^16.

## Operation
- Legal loads: funct3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Legal stores: 000 sb, 001 sh, 010 sw. Any other code is illegal and takes 0 accesses.
- Size S = 1/2/4 bytes; offset o = addr[1:0]; word A = addr & ~3; word B = A + 4, computed mod 2^32.
- Aligned request: o == 0 for lw/sw, o[0] == 0 for halfword, always for bytes.
  - One access in state ACCESS.
  - `dm_addr` = addr and `dm_funct3` = funct3 are passed through unchanged.
  - Loads take `dm_dataR` directly.
- Misaligned load:
  - LD_LO reads A with funct3 010.
  - If o + S > 4, LD_HI then reads B with funct3 010; otherwise B data is treated as 0.
  - Result = bits [8S-1:0] of ({B,A} >> 8o), then sign-extended (lh) or zero-extended (lhu).
- Misaligned store:
  - ST_BYTE issues S byte writes (funct3 000), one per cycle.
  - Write i goes to address addr+i (mod 2^32) with `dm_dataW[7:0]` = wdata byte i; i counts 0..S-1 on a 2-bit counter.
- States: IDLE, ACCESS, LD_LO, LD_HI, ST_BYTE, RESP.
  - IDLE/RESP → ACCESS | LD_LO | ST_BYTE on accept.
  - IDLE/RESP → RESP on accept of an illegal request.
  - LD_LO → LD_HI if crossing, else RESP; LD_HI → RESP.
  - ST_BYTE → RESP after byte S-1.
  - ACCESS → RESP.
  - RESP → IDLE if no accept in that cycle.
- Request fields are latched on accept; the inputs may change afterwards.
- `dm_MemRW` = 1 only in ACCESS for a store, and in ST_BYTE. `dm_*` outputs are 0 in IDLE and RESP.
- No address range check is done here; out-of-range behaviour belongs to `data_mem`.
- `split_cnt` increments on accept of any legal misaligned request.

## Timing
- `req_ready` = 1 in IDLE and RESP, 0 otherwise. This allows back-to-back accept during the response cycle.
- Request accepted on edge k with n accesses occupies cycles k+1..k+n. `rsp_valid` = 1 in cycle k+n+1 only.
  - n = 1 aligned; 1 or 2 for misaligned loads; S for misaligned stores; 0 for illegal (response in k+1).
- Load data is sampled from `dm_dataR` at the end of each read cycle. `rsp_rdata` and `rsp_err` are registered and held only during `rsp_valid`; they are 0 otherwise.
- Reset values: `rsp_valid`, `rsp_rdata`, `rsp_err`, `split_cnt` = 0; all `dm_*` = 0; state IDLE, so `req_ready` = 1 once `rst_n` is high.
- Reset mid-operation: the operation is abandoned immediately. Bytes already written stay in memory, no further write is issued, and no response is produced.

## Test plan
- Aligned lw: mem[0x10] = 0x44332211, lw 0x10 accepted at k → cycle k+1 `dm_addr` 0x10, `dm_funct3` 010, `dm_MemRW` 0; k+2 `rsp_rdata` 0x44332211, `rsp_err` 0, `split_cnt` 0.
- Misaligned lw 0x11, mem[0x14] = 0x88776655 → `dm_addr` 0x10 then 0x14; k+3 `rsp_rdata` 0x55443322; `split_cnt` 1.
- Crossing halfword: mem[0x14] = 0x887766F5; lh 0x13 → `rsp_rdata` 0xFFFFF544 at k+3; lhu 0x13 → 0x0000F544; lh 0x11 (non-crossing) → one read, 0x00003322 at k+2.
- Misaligned sw 0x21 data 0xA1B2C3D4 → writes at k+1..k+4 to 0x21..0x24 with data D4, C3, B2, A1 and funct3 000; `rsp_valid` at k+5. Then lw 0x20 → 0xB2C3D411 and lw 0x24 → 0x887766A1.
- Illegal: load funct3 011 and store funct3 100 → `dm_MemRW` stays 0, no `dm_addr` activity, `rsp_valid` and `rsp_err` = 1 at k+1, `rsp_rdata` 0. Back-to-back: a new aligned lw held valid during RESP is accepted there.
- Reset mid-store: sw 0x31 data 0x11223344, `rst_n` low after 2 byte writes → only 0x31 and 0x32 are modified, no `rsp_valid`; after release `req_ready` = 1 and `split_cnt` = 0.
